// File: rtl/fetch_exec_ctrl.sv
// Fetch/dispatch/execute sequencer that owns PC stepping and branching.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_exec_ctrl #(
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [7:0]         pc_cur,
  output logic               pc_inc_en,
  output logic [7:0]         pc_next,
  output logic               mem_req,
  output logic [7:0]         mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [7:0]         branch_target,
  input  logic               halt,
  output logic               halted,
  output logic [15:0]        retire_cnt,
  output logic               fault
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DISPATCH, EXEC, UPDATE, HALT, FAULT
  } state_t;

  state_t     state;
  logic       br_lat;
  logic       halt_lat;
  logic [7:0] tgt_lat;

`ifdef FETCH_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] tcnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      instr      <= '0;
      retire_cnt <= '0;
      br_lat     <= 1'b0;
      halt_lat   <= 1'b0;
      tgt_lat    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
`ifdef FETCH_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        FETCH: begin
          if (mem_ack) begin
            instr <= mem_rdata;
            state <= DISPATCH;
          end
`ifdef FETCH_TIMEOUT_EN
          // An ack in the last allowed cycle still wins over the timeout.
          else if (tcnt == TCW'(TIMEOUT_CYC - 1)) state <= FAULT;
          else tcnt <= tcnt + 1'b1;
`endif
        end
        DISPATCH: if (instr_ready) state <= EXEC;
        EXEC: begin
          if (exec_done) begin
            br_lat   <= branch_taken;
            tgt_lat  <= branch_target;
            halt_lat <= halt;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          retire_cnt <= retire_cnt + 16'd1;
          if (halt_lat)  state <= HALT;
          else if (run)  state <= FETCH;
          else           state <= IDLE;
`ifdef FETCH_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        HALT:    state <= HALT;
        default: state <= state;
      endcase
    end
  end

  // The PC reloads pc_in whenever pc_inc_en is low, so pc_next mirrors
  // pc_cur except for the branch cycle.
  assign mem_req     = (state == FETCH);
  assign mem_addr    = pc_cur;
  assign instr_valid = (state == DISPATCH);
  assign pc_inc_en   = (state == UPDATE) && !br_lat;
  assign pc_next     = ((state == UPDATE) && br_lat) ? tgt_lat : pc_cur;
  assign halted      = (state == HALT);
`ifdef FETCH_TIMEOUT_EN
  assign fault       = (state == FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Scoreboard bench for fetch_exec_ctrl with a behavioural PC and memory.
module tb_fetch_exec_ctrl;
  localparam int IW = 16;

  logic          clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic          mem_ack = 1'b0, instr_ready = 1'b0, exec_done = 1'b0;
  logic          branch_taken = 1'b0, halt = 1'b0;
  logic [7:0]    branch_target = 8'h00;
  logic [7:0]    pc = 8'h10;
  logic [IW-1:0] mem_rdata = '0;

  logic          pc_inc_en, mem_req, instr_valid, halted, fault;
  logic [7:0]    pc_next, mem_addr;
  logic [IW-1:0] instr;
  logic [15:0]   retire_cnt;

  int            checks = 0, errors = 0, cyc = 0, t0;
  logic [IW-1:0] instr_q[$];
  logic [7:0]    pc_q[$];
  logic [15:0]   exp_ret = 16'd0;
  logic [7:0]    p;

  always #5 clk = ~clk;

  // Program counter: increments on strobe, otherwise loads pc_in.
  always @(posedge clk) pc <= pc_inc_en ? pc + 8'd1 : pc_next;

  fetch_exec_ctrl #(.INSTR_W(IW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_cur(pc),
    .pc_inc_en(pc_inc_en), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .halted(halted), .retire_cnt(retire_cnt), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    cyc++;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the following state.
  task automatic do_instr(input logic br, input logic [7:0] tgt, input logic hlt,
                          input int rdy_dly, input int ex_dly, input logic drop);
    logic [IW-1:0] e;
    logic [7:0]    np;
    chk("f_req", 32'(mem_req), 1);
    chk("f_addr", 32'(mem_addr), 32'(pc_q.pop_front()));
    chk("f_pc_hold", 32'(pc_next), 32'(pc));
    mem_rdata = IW'($urandom);
    mem_ack   = 1'b1;
    instr_q.push_back(mem_rdata);
    step;
    mem_ack   = 1'b0;
    mem_rdata = '1;
    e = instr_q.pop_front();
    chk("d_req", 32'(mem_req), 0);
    chk("d_valid", 32'(instr_valid), 1);
    chk("d_instr", 32'(instr), 32'(e));
    instr_ready = (rdy_dly == 0);
    for (int i = 0; i < rdy_dly; i++) begin
      exec_done = 1'b1;
      halt      = 1'b1;
      step;
      exec_done = 1'b0;
      halt      = 1'b0;
      chk("d_hold_valid", 32'(instr_valid), 1);
      chk("d_hold_instr", 32'(instr), 32'(e));
      chk("d_pc_hold", 32'(pc_next), 32'(pc));
      if (i == rdy_dly - 1) instr_ready = 1'b1;
    end
    step;
    instr_ready = 1'b0;
    chk("e_valid", 32'(instr_valid), 0);
    chk("e_inc", 32'(pc_inc_en), 0);
    chk("e_pc_hold", 32'(pc_next), 32'(pc));
    if (drop) run = 1'b0;
    for (int i = 0; i < ex_dly; i++) begin
      mem_ack = 1'b1;
      step;
      mem_ack = 1'b0;
      chk("e_instr_stable", 32'(instr), 32'(e));
      chk("e_req", 32'(mem_req), 0);
    end
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
    np = br ? tgt : pc + 8'd1;
    pc_q.push_back(np);
    step;
    exec_done     = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 8'h5A;
    halt          = ~hlt;
    chk("u_inc", 32'(pc_inc_en), 32'(!br));
    if (br) chk("u_next", 32'(pc_next), 32'(np));
    else    chk("u_next", 32'(pc_next), 32'(pc));
    chk("u_ret", 32'(retire_cnt), 32'(exp_ret));
    exp_ret++;
    step;
    branch_taken = 1'b0;
    halt         = 1'b0;
    chk("ret", 32'(retire_cnt), 32'(exp_ret));
    chk("pc_upd", 32'(pc), 32'(np));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_inc", 32'(pc_inc_en), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_ret", 32'(retire_cnt), 0);
    rst = 1'b0;
    pc_q.push_back(8'h10);
    run = 1'b1;
    step;
    t0 = cyc;
    do_instr(1'b0, 8'h00, 1'b0, 0, 1, 1'b0);
    chk("lat5", 32'(cyc - t0), 5);
    do_instr(1'b1, 8'h42, 1'b0, 0, 1, 1'b0);
    do_instr(1'b0, 8'h00, 1'b0, 3, 0, 1'b0);
    do_instr(1'b1, 8'h43, 1'b0, 1, 2, 1'b0);
    do_instr(1'b0, 8'h00, 1'b0, 0, 1, 1'b1);
    chk("idle_req", 32'(mem_req), 0);
    p = pc;
    repeat (3) begin
      step;
      chk("idle_req_hold", 32'(mem_req), 0);
      chk("idle_pc", 32'(pc), 32'(p));
    end
    run = 1'b1;
    step;
    do_instr(1'b0, 8'h00, 1'b1, 0, 1, 1'b0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_req", 32'(mem_req), 0);
    p = pc;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      step;
      chk("halt_stay", 32'(halted), 1);
      chk("halt_no_req", 32'(mem_req), 0);
      chk("halt_pc", 32'(pc), 32'(p));
    end
    rst = 1'b1;
    #1;
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_ret", 32'(retire_cnt), 0);
    rst = 1'b0;
    pc_q.delete();
    exp_ret = 16'd0;
    run = 1'b1;
    step;
    chk("rf_req", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("rf_req_drop", 32'(mem_req), 0);
    chk("rf_valid", 32'(instr_valid), 0);
    rst       = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    step;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 0);
    chk("late_ack_valid", 32'(instr_valid), 0);
    chk("late_ack_instr", 32'(instr), 0);
`ifdef FETCH_TIMEOUT_EN
    run = 1'b1;
    step;
    p = pc;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(mem_req), 1);
      chk("to_fault_early", 32'(fault), 0);
      step;
    end
    chk("to_fault", 32'(fault), 1);
    chk("to_req_off", 32'(mem_req), 0);
    chk("to_halted", 32'(halted), 0);
    chk("to_pc", 32'(pc), 32'(p));
    for (int i = 0; i < 3; i++) begin
      run = i[0];
      step;
      chk("to_sticky", 32'(fault), 1);
    end
`else
    run = 1'b1;
    repeat (20) begin
      step;
      chk("no_fault", 32'(fault), 0);
    end
    chk("wait_req", 32'(mem_req), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
Instruction-sequencing FSM that owns the 8-bit program counter. It fetches an instruction from program memory at the current PC, hands it to the execute unit, and then drives the PC's pc_in/pc_inc_en inputs to step or branch. It sits between the program counter, program memory and the execute unit.

Parameters:
INSTR_W, 16, instruction word width in bits
TIMEOUT_CYC, 16, cycles allowed for mem_ack before fault (only used with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
run  input  1  level enable; start or continue sequencing
pc_cur  input  8  current PC value (from the program counter's pc_out)
pc_inc_en  output  1  PC increment strobe (to the program counter)
pc_next  output  8  PC load value (to the program counter's pc_in)
mem_req  output  1  program memory read request
mem_addr  output  8  program memory read address
mem_ack  input  1  read data valid, one-cycle pulse
mem_rdata  input  INSTR_W  read data
instr  output  INSTR_W  latched instruction
instr_valid  output  1  instruction offered to execute unit
instr_ready  input  1  execute unit accepts the instruction
exec_done  input  1  execute complete, one-cycle pulse
branch_taken  input  1  qualified by exec_done
branch_target  input  8  qualified by exec_done
halt  input  1  qualified by exec_done; stop after this instruction
halted  output  1  in HALT state
retire_cnt  output  16  retired instruction count
fault  output  1  fetch timeout (feature only; else tied 0)

Behaviour:
- States: IDLE, FETCH, DISPATCH, EXEC, UPDATE, HALT, plus FAULT with the feature. All outputs are Moore, decoded from registered state and registers.
- Reset (async): state IDLE; mem_req=0, instr_valid=0, pc_inc_en=0, halted=0, fault=0, instr=0, retire_cnt=0, branch and halt latches=0.
- PC hold rule: the program counter loads pc_in whenever pc_inc_en=0. Therefore pc_next=pc_cur combinationally in every state except UPDATE-with-branch. The PC must never change outside UPDATE.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: mem_req=1 and mem_addr=pc_cur for the whole state. When mem_ack=1, capture mem_rdata into instr and go to DISPATCH. mem_req is low the cycle after ack. mem_ack in the first FETCH cycle is legal; minimum fetch is 1 cycle.
- DISPATCH: instr_valid=1 and instr held stable. On instr_valid and instr_ready in the same cycle, go to EXEC; instr_valid is low the next cycle.
- EXEC: wait for exec_done. When it arrives, latch branch_taken, branch_target and halt, then go to UPDATE.
- UPDATE: exactly one cycle.
  - Branch latched: pc_inc_en=0 and pc_next=latched target.
  - Otherwise: pc_inc_en=1.
  - retire_cnt increments (wraps 0xFFFF->0).
  - Next state: HALT if halt latched; else FETCH if run=1; else IDLE.
- PC wrap 0xFF->0x00 is a PC concern; no special handling here. A branch to its own address is legal.
- HALT: halted=1, PC held, no requests. Leaves HALT only on rst; run is ignored.
- run dropped mid-instruction: the current instruction completes through UPDATE, then the FSM returns to IDLE.
- Stray pulses: mem_ack outside FETCH and exec_done outside EXEC are ignored.
- Reset mid-operation: mem_req and instr_valid drop asynchronously, and any pending ack or done is discarded.
- Minimum instruction latency (ack and ready immediate, exec_done the cycle after EXEC entry): 5 cycles, FETCH to the next FETCH.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter runs while in FETCH. If mem_ack has not arrived after TIMEOUT_CYC cycles, the FSM enters FAULT: fault=1, mem_req=0, PC held. FAULT is sticky until rst; halted stays 0.
- Undefined: FETCH waits indefinitely, no counter logic is present, and fault is tied 0.

Test Plan:
- Reset then run=1, pc_cur=0x10, ack/ready/done immediate, no branch -> mem_addr=0x10, one pc_inc_en pulse in UPDATE, retire_cnt=1, next FETCH 5 cycles after the first.
- exec_done with branch_taken=1, target=0x42 -> UPDATE has pc_inc_en=0, pc_next=0x42; pc_next==pc_cur in all other cycles.
- instr_ready held low 3 cycles -> instr_valid stays high and instr is stable; EXEC is entered the cycle after ready.
- exec_done with halt=1 -> PC updates once, halted=1; run toggling leaves no mem_req until rst.
- run dropped during EXEC -> UPDATE completes, IDLE entered, mem_req stays 0; rst asserted mid-FETCH -> mem_req=0 immediately, a late mem_ack is ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, no mem_ack -> fault=1 after 4 FETCH cycles, mem_req=0, PC unchanged.
